// File: rtl/dw_mode_ctrl.sv
// Mode/set sequencer for the digital watch: turns mode/set button levels into a
// four-state mode FSM plus single-cycle strobes to the time and stopwatch counters.
module dw_mode_ctrl #(
  parameter int TIMEOUT_S = 10,
  parameter int BLINK_EN  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic       set,
  input  logic       tick_1hz,
  output logic [1:0] state,
  output logic       hr_inc,
  output logic       min_inc,
  output logic       sec_clr,
  output logic       sw_run,
  output logic       sw_clr,
  output logic       blink
);

  typedef enum logic [1:0] {
    ST_TIME      = 2'd0,
    ST_SET_HR    = 2'd1,
    ST_SET_MIN   = 2'd2,
    ST_STOPWATCH = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_S - 1);

  state_t     cur_state, nxt_state;
  logic       mode_q, set_q;
  logic       mode_e, set_e, in_set;
  logic [7:0] tcnt, tcnt_n;
  logic       hr_inc_n, min_inc_n, sec_clr_n, sw_run_n, sw_clr_n, blink_n;

  assign mode_e = mode & ~mode_q;
  assign set_e  = set & ~set_q;
  assign in_set = (cur_state == ST_SET_HR) || (cur_state == ST_SET_MIN);
  assign state  = cur_state;

  // History registers reset high so a button held through reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= ST_TIME;
      mode_q    <= 1'b1;
      set_q     <= 1'b1;
      tcnt      <= 8'd0;
      hr_inc    <= 1'b0;
      min_inc   <= 1'b0;
      sec_clr   <= 1'b0;
      sw_run    <= 1'b0;
      sw_clr    <= 1'b0;
      blink     <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      mode_q    <= mode;
      set_q     <= set;
      tcnt      <= tcnt_n;
      hr_inc    <= hr_inc_n;
      min_inc   <= min_inc_n;
      sec_clr   <= sec_clr_n;
      sw_run    <= sw_run_n;
      sw_clr    <= sw_clr_n;
      blink     <= blink_n;
    end
  end

  // Priority: stopwatch clear combo, then mode edge, then set edge, then 1 Hz tick.
  always_comb begin
    nxt_state = cur_state;
    tcnt_n    = tcnt;
    hr_inc_n  = 1'b0;
    min_inc_n = 1'b0;
    sec_clr_n = 1'b0;
    sw_clr_n  = 1'b0;
    sw_run_n  = sw_run;
    blink_n   = blink;

    if (mode_e && set_e && (cur_state == ST_STOPWATCH)) begin
      sw_clr_n = 1'b1;
      sw_run_n = 1'b0;
      tcnt_n   = 8'd0;
    end else if (mode_e) begin
      tcnt_n  = 8'd0;
      blink_n = 1'b0;
      case (cur_state)
        ST_TIME:      nxt_state = ST_SET_HR;
        ST_SET_HR:    nxt_state = ST_SET_MIN;
        ST_SET_MIN:   nxt_state = ST_STOPWATCH;
        default:      nxt_state = ST_TIME;
      endcase
    end else if (set_e) begin
      tcnt_n = 8'd0;
      case (cur_state)
        ST_SET_HR:    hr_inc_n = 1'b1;
        ST_SET_MIN: begin
          min_inc_n = 1'b1;
          sec_clr_n = 1'b1;
        end
        ST_STOPWATCH: sw_run_n = ~sw_run;
        default:      ;
      endcase
    end else if (tick_1hz && in_set) begin
      if (tcnt == TIMEOUT_LAST) begin
        nxt_state = ST_TIME;
        tcnt_n    = 8'd0;
        blink_n   = 1'b0;
      end else begin
        tcnt_n = tcnt + 8'd1;
        if (BLINK_EN != 0) blink_n = ~blink;
      end
    end
  end

endmodule

// File: tb/tb_dw_mode_ctrl.sv
// Scoreboard bench for dw_mode_ctrl: every change of the output vector is popped
// from an expectation queue and checked for value and the cycle it appears in.
module tb_dw_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode, set, tick_1hz;
  logic [1:0] state;
  logic       hr_inc, min_inc, sec_clr, sw_run, sw_clr, blink;

  typedef struct {
    logic [7:0] vec;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc_cnt = 0;
  logic [7:0] prev_vec = 8'h00;
  logic [7:0] bl;

  dw_mode_ctrl #(.TIMEOUT_S(10), .BLINK_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .set(set), .tick_1hz(tick_1hz),
    .state(state), .hr_inc(hr_inc), .min_inc(min_inc), .sec_clr(sec_clr),
    .sw_run(sw_run), .sw_clr(sw_clr), .blink(blink)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [7:0] mk(input logic [1:0] st, input logic hr, input logic mn,
                                    input logic sc, input logic run, input logic clr,
                                    input logic bk);
    return {st, hr, mn, sc, run, clr, bk};
  endfunction

  function automatic logic [7:0] out_vec();
    return {state, hr_inc, min_inc, sec_clr, sw_run, sw_clr, blink};
  endfunction

  task automatic push_exp(input logic [7:0] v, input int off);
    sb.push_back('{vec: v, cyc: cyc_cnt + off});
  endtask

  task automatic apply_stimulus(input logic m, input logic s, input logic t);
    mode     = m;
    set      = s;
    tick_1hz = t;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic mode_pulse(input logic [7:0] expect_vec);
    push_exp(expect_vec, 1);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp_v);
    end
  endtask

  // Monitor: any change in the registered outputs must match the next queued expectation.
  always @(negedge clk) begin
    logic [7:0] cur;
    exp_t       e;
    cur = out_vec();
    if (cur !== prev_vec) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_change: got %b at cycle %0d, expected no change",
                 cur, cyc_cnt);
      end else begin
        e = sb.pop_front();
        if (cur !== e.vec || cyc_cnt != e.cyc) begin
          fails++;
          $display("[TB] FAIL output_event: got %b at cycle %0d, expected %b at cycle %0d",
                   cur, cyc_cnt, e.vec, e.cyc);
        end
      end
      prev_vec = cur;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mode = 1'b1; set = 1'b0; tick_1hz = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_state", out_vec(), 8'h00);

    // Mode held high through reset release: no edge until it drops and rises again.
    rst_n = 1'b1;
    repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    push_exp(mk(2'd1, 0, 0, 0, 0, 0, 0), 1);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    idle(1);

    mode_pulse(mk(2'd2, 0, 0, 0, 0, 0, 0));
    mode_pulse(mk(2'd3, 0, 0, 0, 0, 0, 0));
    mode_pulse(mk(2'd0, 0, 0, 0, 0, 0, 0));

    // Long press from TIME gives a single transition.
    push_exp(mk(2'd1, 0, 0, 0, 0, 0, 0), 1);
    repeat (5) apply_stimulus(1'b1, 1'b0, 1'b0);
    idle(1);

    repeat (3) begin
      push_exp(mk(2'd1, 1, 0, 0, 0, 0, 0), 1);
      push_exp(mk(2'd1, 0, 0, 0, 0, 0, 0), 2);
      apply_stimulus(1'b0, 1'b1, 1'b0);
      idle(1);
    end

    mode_pulse(mk(2'd2, 0, 0, 0, 0, 0, 0));
    push_exp(mk(2'd2, 0, 1, 1, 0, 0, 0), 1);
    push_exp(mk(2'd2, 0, 0, 0, 0, 0, 0), 2);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    idle(1);

    mode_pulse(mk(2'd3, 0, 0, 0, 0, 0, 0));
    push_exp(mk(2'd3, 0, 0, 0, 1, 0, 0), 1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    idle(1);
    mode_pulse(mk(2'd0, 0, 0, 0, 1, 0, 0));

    // Set in TIME is ignored; stopwatch keeps running in the background.
    apply_stimulus(1'b0, 1'b1, 1'b0);
    idle(1);
    mode_pulse(mk(2'd1, 0, 0, 0, 1, 0, 0));
    mode_pulse(mk(2'd2, 0, 0, 0, 1, 0, 0));
    mode_pulse(mk(2'd3, 0, 0, 0, 1, 0, 0));

    push_exp(mk(2'd3, 0, 0, 0, 0, 1, 0), 1);
    push_exp(mk(2'd3, 0, 0, 0, 0, 0, 0), 2);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    idle(1);

    // Timeout from SET_HR after ten ticks, blink toggling on each of the first nine.
    mode_pulse(mk(2'd0, 0, 0, 0, 0, 0, 0));
    mode_pulse(mk(2'd1, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 9; i++) begin
      push_exp(mk(2'd1, 0, 0, 0, 0, 0, (i % 2) == 1), 1);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      idle(1);
    end
    push_exp(mk(2'd0, 0, 0, 0, 0, 0, 0), 1);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    idle(1);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    idle(1);

    // A set press after tick 5 restarts the timeout, so it fires at tick 15.
    mode_pulse(mk(2'd1, 0, 0, 0, 0, 0, 0));
    bl = 8'd0;
    for (int i = 1; i <= 5; i++) begin
      bl[0] = ~bl[0];
      push_exp(mk(2'd1, 0, 0, 0, 0, 0, bl[0]), 1);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      idle(1);
    end
    push_exp(mk(2'd1, 1, 0, 0, 0, 0, bl[0]), 1);
    push_exp(mk(2'd1, 0, 0, 0, 0, 0, bl[0]), 2);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    idle(1);
    for (int i = 6; i <= 14; i++) begin
      bl[0] = ~bl[0];
      push_exp(mk(2'd1, 0, 0, 0, 0, 0, bl[0]), 1);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      idle(1);
    end
    push_exp(mk(2'd0, 0, 0, 0, 0, 0, 0), 1);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    idle(1);

    // Asynchronous reset in STOPWATCH with the stopwatch running.
    mode_pulse(mk(2'd1, 0, 0, 0, 0, 0, 0));
    mode_pulse(mk(2'd2, 0, 0, 0, 0, 0, 0));
    mode_pulse(mk(2'd3, 0, 0, 0, 0, 0, 0));
    push_exp(mk(2'd3, 0, 0, 0, 1, 0, 0), 1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    idle(1);
    push_exp(8'h00, 1);
    #2 rst_n = 1'b0;
    #1 check_output("async_reset", out_vec(), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
